// File: rtl/btn_debounce.sv
// Two-channel push-button debouncer: 2-flop synchronizer, per-channel stability counter, press pulse.
// Optional long-press detector enabled by defining BTN_LONGPRESS_EN (adds o_fLong).
module btn_debounce #(
    parameter int LST_DB   = 1_000_000 - 1,
    parameter int LST_LONG = 200_000_000 - 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [1:0] i_Btn,
    output logic [1:0] o_Btn,
    output logic [1:0] o_fPress
`ifdef BTN_LONGPRESS_EN
    ,
    output logic [1:0] o_fLong
`endif
);

    localparam int DbW = (LST_DB > 0) ? $clog2(LST_DB + 1) : 1;
    localparam logic [DbW-1:0] DbMax = DbW'(LST_DB);

    // The long-press counter needs at least one cycle of hold to be meaningful.
    generate
        if (LST_DB < 0 || LST_LONG < 1) begin : gParamCheck
            $error("btn_debounce: LST_DB must be >= 0 and LST_LONG >= 1");
        end
    endgenerate

    logic [1:0] s1;
    logic [1:0] s2;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            s1 <= 2'b11;
            s2 <= 2'b11;
        end else begin
            s1 <= i_Btn;
            s2 <= s1;
        end
    end

    generate
        for (genvar ch = 0; ch < 2; ch++) begin : gChan
            logic [DbW-1:0] dbCnt;
            logic           btnQ;
            logic           pressQ;

            // Any cycle agreeing with the settled level restarts the window, so glitches never accumulate.
            always_ff @(posedge i_Clk) begin
                if (!i_Rst) begin
                    dbCnt  <= '0;
                    btnQ   <= 1'b1;
                    pressQ <= 1'b0;
                end else begin
                    pressQ <= 1'b0;
                    if (s2[ch] == btnQ) begin
                        dbCnt <= '0;
                    end else if (dbCnt == DbMax) begin
                        btnQ   <= s2[ch];
                        dbCnt  <= '0;
                        pressQ <= ~s2[ch];
                    end else begin
                        dbCnt <= dbCnt + 1'b1;
                    end
                end
            end

            assign o_Btn[ch]    = btnQ;
            assign o_fPress[ch] = pressQ;

`ifdef BTN_LONGPRESS_EN
            localparam int LongW = $clog2(LST_LONG + 1);
            localparam logic [LongW-1:0] LongMax = LongW'(LST_LONG);
            localparam logic [LongW-1:0] LongPre = LongW'(LST_LONG - 1);

            logic [LongW-1:0] holdCnt;
            logic             longQ;

            // Saturation at LongMax is what limits the pulse to once per press.
            always_ff @(posedge i_Clk) begin
                if (!i_Rst) begin
                    holdCnt <= '0;
                    longQ   <= 1'b0;
                end else if (btnQ) begin
                    holdCnt <= '0;
                    longQ   <= 1'b0;
                end else begin
                    if (holdCnt != LongMax) begin
                        holdCnt <= holdCnt + 1'b1;
                    end
                    longQ <= (holdCnt == LongPre);
                end
            end

            assign o_fLong[ch] = longQ;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce (LST_DB=3, LST_LONG=9): stimulus queues expected output events,
// a negedge monitor pops and compares them whenever o_Btn changes or a pulse appears.
module tb_btn_debounce;

    localparam int LST_DB   = 3;
    localparam int LST_LONG = 9;

    typedef struct {
        int         cyc;
        logic [1:0] btn;
        logic [1:0] press;
        logic [1:0] lng;
    } EventRec;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btnIn;
    logic [1:0] btnOut;
    logic [1:0] pressOut;
    logic [1:0] longW;

    int         cycleCnt = 0;
    int         checks   = 0;
    int         fails    = 0;
    bit         stimDone = 1'b0;
    EventRec    expQ[$];

    btn_debounce #(
        .LST_DB  (LST_DB),
        .LST_LONG(LST_LONG)
    ) dut (
        .i_Clk   (clk),
        .i_Rst   (rst),
        .i_Btn   (btnIn),
        .o_Btn   (btnOut),
        .o_fPress(pressOut)
`ifdef BTN_LONGPRESS_EN
        ,
        .o_fLong (longW)
`endif
    );

`ifndef BTN_LONGPRESS_EN
    assign longW = 2'b00;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] btn);
        btnIn = btn;
    endtask

    task automatic expectEvent(input int offset, input logic [1:0] btn,
                               input logic [1:0] press, input logic [1:0] lng);
        EventRec e;
        e.cyc   = cycleCnt + offset;
        e.btn   = btn;
        e.press = press;
        e.lng   = lng;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycleCnt, act, exp);
        end
    endtask

    // Monitor: reset-level checks while reset is held, event scoreboard otherwise.
    initial begin
        logic [1:0] prevBtn;
        EventRec    e;
        prevBtn = 2'b11;
        forever begin
            @(negedge clk);
            if (stimDone) begin
                checkOutput("leftoverEvents", expQ.size(), 0);
                $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
                $finish;
            end else if (!rst) begin
                checkOutput("rstBtn", int'(btnOut), 3);
                checkOutput("rstPress", int'(pressOut), 0);
            end else if (btnOut !== prevBtn || pressOut !== 2'b00 || longW !== 2'b00) begin
                if (expQ.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpectedEvent at cycle %0d: got btn=%b press=%b long=%b, expected none",
                             cycleCnt, btnOut, pressOut, longW);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("evCycle", cycleCnt, e.cyc);
                    checkOutput("evBtn", int'(btnOut), int'(e.btn));
                    checkOutput("evPress", int'(pressOut), int'(e.press));
                    checkOutput("evLong", int'(longW), int'(e.lng));
                end
            end
            prevBtn = btnOut;
        end
    end

    initial begin
        int n;
        $display("[TB] btn_debounce scoreboard bench starting");
        rst   = 1'b0;
        btnIn = 2'b00;
        waitCycles(2);
        rst   = 1'b1;
        applyStimulus(2'b11);
        waitCycles(4);

        // Clean press on start, then release
        applyStimulus(2'b10);
        expectEvent(6, 2'b10, 2'b01, 2'b00);
        waitCycles(8);
        applyStimulus(2'b11);
        expectEvent(6, 2'b11, 2'b00, 2'b00);
        waitCycles(10);

        // Bounce: low 3, high 1, then low
        applyStimulus(2'b10);
        waitCycles(3);
        applyStimulus(2'b11);
        waitCycles(1);
        applyStimulus(2'b10);
        expectEvent(6, 2'b10, 2'b01, 2'b00);
        waitCycles(8);
        applyStimulus(2'b11);
        expectEvent(6, 2'b11, 2'b00, 2'b00);
        waitCycles(10);

        // Simultaneous press and release
        applyStimulus(2'b00);
        expectEvent(6, 2'b00, 2'b11, 2'b00);
        waitCycles(8);
        applyStimulus(2'b11);
        expectEvent(6, 2'b11, 2'b00, 2'b00);
        waitCycles(10);

        // Reset while stop channel counter is at 2
        applyStimulus(2'b01);
        waitCycles(4);
        rst = 1'b0;
        waitCycles(2);
        rst = 1'b1;
        expectEvent(6, 2'b01, 2'b10, 2'b00);
        waitCycles(8);
        applyStimulus(2'b11);
        expectEvent(6, 2'b11, 2'b00, 2'b00);
        waitCycles(10);

        // Long hold on stop for 30 cycles
        applyStimulus(2'b01);
        expectEvent(6, 2'b01, 2'b10, 2'b00);
`ifdef BTN_LONGPRESS_EN
        expectEvent(6 + LST_LONG, 2'b01, 2'b00, 2'b10);
`endif
        waitCycles(30);
        applyStimulus(2'b11);
        expectEvent(6, 2'b11, 2'b00, 2'b00);
        waitCycles(12);

        stimDone = 1'b1;
        n = 0;
        while (n < 5) begin
            @(posedge clk);
            n++;
        end
        $display("[TB] FAIL monitorTimeout: monitor did not finish, expected summary within 5 cycles");
        $fatal(1, "[TB] monitor did not terminate");
    end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter LST_DB, default 1_000_000-1 (10 ms at 100 MHz); the debounce window is LST_DB+1 consecutive stable cycles.
REQ-002 SHALL have parameter LST_LONG, default 200_000_000-1 (2 s); the long-press threshold in cycles, used only under REQ-021.
REQ-003 SHALL have port i_Clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port i_Rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port i_Btn, input, 2 bits: raw asynchronous push buttons, active-low; bit0 is start, bit1 is stop.
REQ-006 SHALL have port o_Btn, output, 2 bits: debounced active-low button levels that drive the stopwatch i_fStart/i_fStop inputs directly.
REQ-007 SHALL have port o_fPress, output, 2 bits: one-cycle active-high pulse on each debounced press (1->0 on o_Btn).

Function
REQ-008 SHALL process each channel independently with identical logic; there SHALL be no cross-channel interaction.
REQ-009 SHALL pass each i_Btn bit through a 2-flop synchronizer (s1, s2) before any other use.
REQ-010 SHALL, per channel, clear the debounce counter to 0 in every cycle where s2 equals the o_Btn bit.
REQ-011 SHALL, per channel, increment the counter by 1 while s2 differs from o_Btn and counter < LST_DB.
REQ-012 SHALL, when counter == LST_DB and s2 differs from o_Btn, load s2 into o_Btn and clear the counter on that same edge.
REQ-013 SHALL change o_Btn exactly LST_DB+3 rising edges after a raw change first sampled by s1, provided the input stays stable throughout.
REQ-014 SHALL restart the full window on any glitch: a single cycle in which s2 returns to the o_Btn value resets the count to 0.
REQ-015 SHALL set the counter width to ceil(log2(LST_DB+1)) bits; the counter SHALL never wrap.
REQ-016 SHALL register o_fPress: it is high only for the first cycle in which o_Btn reads 0 after reading 1; a release (0->1) produces no pulse.
REQ-017 SHALL, when both channels settle on the same edge, update both o_Btn bits and both o_fPress bits in that same cycle.

Reset
REQ-018 SHALL, while i_Rst==0 at a rising edge, set s1=s2=2'b11, o_Btn=2'b11, o_fPress=2'b00, and all counters to 0.
REQ-019 SHALL abandon any debounce in progress when reset is asserted mid-count; after release, a full LST_DB+3 window is required before o_Btn can change.
REQ-020 SHALL hold o_Btn at 2'b11 during reset regardless of i_Btn, so the stopwatch sees no start/stop edge.

Configuration
REQ-021 SHALL, when macro BTN_LONGPRESS_EN is defined, add output o_fLong (2 bits) and a per-channel hold counter that clears while o_Btn==1, increments while o_Btn==0, and saturates at LST_LONG.
REQ-022 SHALL, under BTN_LONGPRESS_EN, register o_fLong high for exactly one cycle on the edge where the hold counter goes from LST_LONG-1 to LST_LONG, i.e. LST_LONG edges after o_Btn falls, and only once per press.
REQ-023 SHALL, when BTN_LONGPRESS_EN is not defined, have no o_fLong port and no hold counters; all other behaviour is unchanged.

Verification (LST_DB=3, LST_LONG=9)
REQ-024 SHALL check reset: i_Rst=0 for 2 edges with i_Btn=2'b00 -> o_Btn=2'b11 and o_fPress=2'b00 throughout.
REQ-025 SHALL check a clean press: i_Btn[0] 1->0 held -> o_Btn[0]=0 exactly 6 edges later, o_fPress[0]=1 for that single cycle, and o_Btn[1] unaffected.
REQ-026 SHALL check a bounce: i_Btn[0] low 3 cycles, high 1 cycle, then low -> no change until 6 edges after the final transition, with one o_fPress[0] pulse.
REQ-027 SHALL check a simultaneous press: i_Btn 11->00 -> o_Btn=00 and o_fPress=2'b11 on the same edge, 6 edges later; a later release -> o_Btn=11 with no pulse.
REQ-028 SHALL check reset mid-count: i_Btn[1]=0, then i_Rst=0 at count 2, then release -> o_Btn[1] falls 6 edges after release, not earlier.
REQ-029 SHALL check long press (BTN_LONGPRESS_EN): hold i_Btn[1]=0 for 30 cycles -> one o_fLong[1] pulse 9 edges after o_Btn[1] falls, and none for the rest of the hold.
